// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// fills the IF/ID register, with a one-entry skid buffer for decode stalls.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_IR   = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] toPipe1PC,
    output logic [15:0] toPipe1IR,
    output logic        toPipe1Valid,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] S_ISSUE   = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_SKID    = 2'd3;

    // Handshake: a request transfers on a cycle with imem_req=1 and imem_gnt=1;
    // imem_addr is held while imem_req=1; the single response is the later
    // cycle with imem_valid=1 carrying imem_rdata.
    logic [1:0]  state;
    logic [15:0] pc;
    logic [15:0] req_pc;
    logic [15:0] skid_pc;
    logic [15:0] skid_ir;
    logic        load_mem;
    logic        load_skid;

    // Reset gates the request so nothing is offered during the reset cycle.
    assign imem_req  = (state == S_ISSUE) && !reset;
    assign imem_addr = pc;
    assign fsm_state = state;

    always_comb begin
        load_mem  = (state == S_WAIT) && imem_valid && !redirect && !stall;
        load_skid = (state == S_SKID) && !redirect && !stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_ISSUE;
            pc           <= RESET_PC;
            req_pc       <= 16'h0000;
            skid_pc      <= 16'h0000;
            skid_ir      <= 16'h0000;
            toPipe1Valid <= 1'b0;
            toPipe1IR    <= NOP_IR;
            toPipe1PC    <= 16'h0000;
        end else begin
            case (state)
                S_ISSUE: begin
                    if (imem_gnt) begin
                        req_pc <= pc;
                        pc     <= pc + 16'd1;
                        state  <= redirect ? S_DISCARD : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        state <= imem_valid ? S_ISSUE : S_DISCARD;
                    end else if (imem_valid) begin
                        if (stall) begin
                            skid_pc <= req_pc;
                            skid_ir <= imem_rdata;
                            state   <= S_SKID;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_DISCARD: begin
                    if (imem_valid) state <= S_ISSUE;
                end
                S_SKID: begin
                    // A flush without redirect keeps the skid entry for later.
                    if (redirect || (!stall && !flush)) state <= S_ISSUE;
                end
                default: state <= S_ISSUE;
            endcase

            if (redirect) pc <= redirect_pc;

            if (flush) begin
                toPipe1Valid <= 1'b0;
                toPipe1IR    <= NOP_IR;
            end else if (!stall) begin
                if (load_mem) begin
                    toPipe1Valid <= 1'b1;
                    toPipe1PC    <= req_pc;
                    toPipe1IR    <= imem_rdata;
                end else if (load_skid) begin
                    toPipe1Valid <= 1'b1;
                    toPipe1PC    <= skid_pc;
                    toPipe1IR    <= skid_ir;
                end else begin
                    toPipe1Valid <= 1'b0;
                    toPipe1IR    <= NOP_IR;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table plus randomized memory/stall/redirect
// traffic checked against a transaction-order reference model.
module tb_fetch_stage;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_W = 2'd1;
    localparam logic [1:0] ST_D = 2'd2;
    localparam logic [1:0] ST_S = 2'd3;
    localparam logic [15:0] NOP = 16'hF000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] toPipe1PC;
    logic [15:0] toPipe1IR;
    logic        toPipe1Valid;
    logic [1:0]  fsm_state;

    int vec_cnt = 0;
    int miss_cnt = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .toPipe1PC(toPipe1PC), .toPipe1IR(toPipe1IR), .toPipe1Valid(toPipe1Valid),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  f;      // {reset, gnt, valid, stall, flush, redirect}
        logic [15:0] rpc;
        logic [15:0] rdata;
        logic        ereq;
        logic [15:0] eaddr;
        logic        ev;
        logic [15:0] epc;
        logic [15:0] eir;
        logic [1:0]  est;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] f, input logic [15:0] rpc, input logic [15:0] rdata,
                                input logic ereq, input logic [15:0] eaddr, input logic ev,
                                input logic [15:0] epc, input logic [15:0] eir, input logic [1:0] est);
        vec_t v;
        v.f = f; v.rpc = rpc; v.rdata = rdata; v.ereq = ereq; v.eaddr = eaddr;
        v.ev = ev; v.epc = epc; v.eir = eir; v.est = est;
        return v;
    endfunction

    task automatic apply_vec(input string name, input vec_t v);
        @(negedge clk);
        {reset, imem_gnt, imem_valid, stall, flush, redirect} = v.f;
        redirect_pc = v.rpc;
        imem_rdata  = v.rdata;
        @(posedge clk);
        #1;
        check(name, {12'h0, imem_req, imem_addr, toPipe1Valid, toPipe1PC, toPipe1IR, fsm_state},
                    {12'h0, v.ereq, v.eaddr, v.ev, v.epc, v.eir, v.est});
    endtask

    vec_t tbl[34];

    // Reference model state for the random phase.
    logic [15:0] exp_q[$];
    logic [15:0] exp_addr;
    logic        pend;
    int          wcnt;
    logic [15:0] pend_addr;
    int          n_deliv;

    initial begin
        logic        c_rst, c_gnt, c_vld, c_stl, c_fls, c_rdr;
        logic [15:0] c_rpc, c_addr, p_pc, p_ir, e_pc;
        logic        p_v;

        tbl[0]  = mk(6'b100000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, NOP, ST_I);
        tbl[1]  = mk(6'b100000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, NOP, ST_I);
        tbl[2]  = mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0001, 0, 16'h0000, NOP, ST_W);
        tbl[3]  = mk(6'b001000, 16'h0000, 16'h1000, 1, 16'h0001, 1, 16'h0000, 16'h1000, ST_I);
        tbl[4]  = mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0002, 0, 16'h0000, NOP, ST_W);
        tbl[5]  = mk(6'b001000, 16'h0000, 16'h1001, 1, 16'h0002, 1, 16'h0001, 16'h1001, ST_I);
        tbl[6]  = mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0003, 0, 16'h0001, NOP, ST_W);
        tbl[7]  = mk(6'b001000, 16'h0000, 16'h1002, 1, 16'h0003, 1, 16'h0002, 16'h1002, ST_I);
        tbl[8]  = mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0004, 0, 16'h0002, NOP, ST_W);
        tbl[9]  = mk(6'b001000, 16'h0000, 16'h1003, 1, 16'h0004, 1, 16'h0003, 16'h1003, ST_I);
        tbl[10] = mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0005, 0, 16'h0003, NOP, ST_W);
        tbl[11] = mk(6'b001000, 16'h0000, 16'h1004, 1, 16'h0005, 1, 16'h0004, 16'h1004, ST_I);
        tbl[12] = mk(6'b010100, 16'h0000, 16'h0000, 0, 16'h0006, 1, 16'h0004, 16'h1004, ST_W);
        tbl[13] = mk(6'b001100, 16'h0000, 16'h1005, 0, 16'h0006, 1, 16'h0004, 16'h1004, ST_S);
        tbl[14] = mk(6'b000100, 16'h0000, 16'h0000, 0, 16'h0006, 1, 16'h0004, 16'h1004, ST_S);
        tbl[15] = mk(6'b000100, 16'h0000, 16'h0000, 0, 16'h0006, 1, 16'h0004, 16'h1004, ST_S);
        tbl[16] = mk(6'b000000, 16'h0000, 16'h0000, 1, 16'h0006, 1, 16'h0005, 16'h1005, ST_I);
        tbl[17] = mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0007, 0, 16'h0005, NOP, ST_W);
        tbl[18] = mk(6'b000001, 16'h0040, 16'h0000, 0, 16'h0040, 0, 16'h0005, NOP, ST_D);
        tbl[19] = mk(6'b000000, 16'h0000, 16'h0000, 0, 16'h0040, 0, 16'h0005, NOP, ST_D);
        tbl[20] = mk(6'b001000, 16'h0000, 16'h1006, 1, 16'h0040, 0, 16'h0005, NOP, ST_I);
        tbl[21] = mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0041, 0, 16'h0005, NOP, ST_W);
        tbl[22] = mk(6'b001100, 16'h0000, 16'h1040, 0, 16'h0041, 0, 16'h0005, NOP, ST_S);
        tbl[23] = mk(6'b000111, 16'h0080, 16'h0000, 1, 16'h0080, 0, 16'h0005, NOP, ST_I);
        tbl[24] = mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0081, 0, 16'h0005, NOP, ST_W);
        tbl[25] = mk(6'b001000, 16'h0000, 16'h1080, 1, 16'h0081, 1, 16'h0080, 16'h1080, ST_I);
        tbl[26] = mk(6'b000001, 16'hFFFF, 16'h0000, 1, 16'hFFFF, 0, 16'h0080, NOP, ST_I);
        tbl[27] = mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0080, NOP, ST_W);
        tbl[28] = mk(6'b001000, 16'h0000, 16'h0FFF, 1, 16'h0000, 1, 16'hFFFF, 16'h0FFF, ST_I);
        tbl[29] = mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0001, 0, 16'hFFFF, NOP, ST_W);
        tbl[30] = mk(6'b100000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, NOP, ST_I);
        tbl[31] = mk(6'b000000, 16'h0000, 16'h0000, 1, 16'h0000, 0, 16'h0000, NOP, ST_I);
        tbl[32] = mk(6'b010001, 16'h0200, 16'h0000, 0, 16'h0200, 0, 16'h0000, NOP, ST_D);
        tbl[33] = mk(6'b001000, 16'h0000, 16'h1000, 1, 16'h0200, 0, 16'h0000, NOP, ST_I);

        for (int i = 0; i < 34; i++) apply_vec($sformatf("tbl_row%0d", i), tbl[i]);

        // Flush alone on a returning fetch: the load is dropped and fetch moves on.
        apply_vec("flush_drop_gnt", mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0201, 0, 16'h0000, NOP, ST_W));
        apply_vec("flush_drop_vld", mk(6'b001010, 16'h0000, 16'h1200, 1, 16'h0201, 0, 16'h0000, NOP, ST_I));
        apply_vec("flush_drop_next", mk(6'b010000, 16'h0000, 16'h0000, 0, 16'h0202, 0, 16'h0000, NOP, ST_W));
        // Redirect coinciding with valid in WAIT: data dropped, ISSUE at target at once.
        apply_vec("rdr_with_vld", mk(6'b001001, 16'h0300, 16'h1201, 1, 16'h0300, 0, 16'h0000, NOP, ST_I));

        // Randomized phase: memory with 1..3 cycle latency, random grant, stall, redirect.
        exp_q.delete();
        exp_addr = 16'h0000;
        pend = 1'b0;
        wcnt = 0;
        pend_addr = 16'h0000;
        n_deliv = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset       = (c < 2);
            redirect    = ($urandom_range(0, 15) == 0);
            flush       = redirect && ($urandom_range(0, 1) == 1);
            redirect_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                                      : 16'($urandom_range(0, 65535));
            stall       = ($urandom_range(0, 3) == 0);
            imem_gnt    = imem_req && !pend && ($urandom_range(0, 1) == 1);
            imem_valid  = pend && (wcnt == 0);
            imem_rdata  = 16'h1000 + pend_addr;
            p_v = toPipe1Valid; p_pc = toPipe1PC; p_ir = toPipe1IR;
            check("req_while_busy", {63'h0, imem_req && pend}, 64'h0);
            @(posedge clk);
            c_rst = reset; c_gnt = imem_gnt; c_vld = imem_valid; c_stl = stall;
            c_fls = flush; c_rdr = redirect; c_rpc = redirect_pc; c_addr = imem_addr;
            #1;
            if (c_rst) begin
                exp_q.delete();
                exp_addr = 16'h0000;
                pend = 1'b0;
                check("rnd_reset", {toPipe1Valid, toPipe1PC, toPipe1IR}, {1'b0, 16'h0000, NOP});
            end else begin
                if (c_vld) pend = 1'b0;
                else if (pend) wcnt--;
                if (c_gnt) begin
                    check("rnd_fetch_addr", {48'h0, c_addr}, {48'h0, exp_addr});
                    exp_q.push_back(c_addr);
                    exp_addr = c_addr + 16'd1;
                    pend = 1'b1;
                    wcnt = $urandom_range(0, 2);
                    pend_addr = c_addr;
                end
                if (c_rdr) begin
                    exp_q.delete();
                    exp_addr = c_rpc;
                end
                if (c_fls) begin
                    check("rnd_flush", {toPipe1Valid, toPipe1PC, toPipe1IR}, {1'b0, p_pc, NOP});
                end else if (c_stl) begin
                    check("rnd_stall_hold", {toPipe1Valid, toPipe1PC, toPipe1IR}, {p_v, p_pc, p_ir});
                end else if (toPipe1Valid) begin
                    n_deliv++;
                    if (exp_q.size() == 0) begin
                        check("rnd_unexpected_instr", {48'h0, toPipe1PC}, 64'hFFFF_FFFF);
                    end else begin
                        e_pc = exp_q.pop_front();
                        check("rnd_deliver", {toPipe1PC, toPipe1IR}, {e_pc, 16'h1000 + e_pc});
                    end
                end else begin
                    check("rnd_bubble", {toPipe1PC, toPipe1IR}, {p_pc, NOP});
                end
            end
        end
        check("rnd_progress", {63'h0, n_deliv >= 200}, 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
